// File: rtl/stage_execute.sv
// stage_execute: SIMD execute stage, single-cycle ALU ops plus lane-serial MUL.
// Optional macro EXEC_SATURATE_EN makes ADD/SUB saturate per lane (unsigned).
module stage_execute #(
    parameter int vecSize      = 4,
    parameter int registerSize = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  inValid,
    input  logic [2:0]                            aluOp,
    input  logic [vecSize-1:0][registerSize-1:0]  operand1,
    input  logic [vecSize-1:0][registerSize-1:0]  operand2,
    input  logic [registerSize-1:0]               immIn,
    input  logic                                  writeEnableIn,
    input  logic                                  writeMemFromIn,
    input  logic [1:0]                            writeRegFromIn,
    output logic                                  busy,
    output logic                                  outValid,
    output logic [vecSize-1:0][registerSize-1:0]  aluResult,
    output logic [vecSize-1:0][registerSize-1:0]  aluOperand1,
    output logic [vecSize-1:0][registerSize-1:0]  aluOperand2,
    output logic [registerSize-1:0]               imm,
    output logic                                  writeEnable,
    output logic                                  writeMemFrom,
    output logic [1:0]                            writeRegFrom
);
    localparam int LW = vecSize > 1 ? $clog2(vecSize) : 1;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                           OP_XOR = 3'd4, OP_SHL = 3'd5, OP_MUL = 3'd6;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t                                state;
    logic [LW-1:0]                         lane;
    logic                                  accept;
    logic [vecSize-1:0][registerSize-1:0]  comb_res;

    function automatic logic [registerSize-1:0] alu_lane(
        input logic [2:0]              op,
        input logic [registerSize-1:0] a,
        input logic [registerSize-1:0] b
    );
        logic [registerSize-1:0] add, sub;
`ifdef EXEC_SATURATE_EN
        logic [registerSize:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        add = sum[registerSize] ? '1 : sum[registerSize-1:0];
        sub = (a < b) ? '0 : a - b;
`else
        add = a + b;
        sub = a - b;
`endif
        return (op == OP_ADD) ? add :
               (op == OP_SUB) ? sub :
               (op == OP_AND) ? a & b :
               (op == OP_OR)  ? a | b :
               (op == OP_XOR) ? a ^ b :
               (op == OP_SHL) ? a << b[3:0] : a;
    endfunction

    assign accept = inValid && !busy;

    // MUL maps to PASS here; products come from the single lane-serial multiplier below.
    always_comb begin
        comb_res = '0;
        for (int i = 0; i < vecSize; i++)
            comb_res[i] = alu_lane(aluOp, operand1[i], operand2[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            lane         <= '0;
            busy         <= 1'b0;
            outValid     <= 1'b0;
            aluResult    <= '0;
            aluOperand1  <= '0;
            aluOperand2  <= '0;
            imm          <= '0;
            writeEnable  <= 1'b0;
            writeMemFrom <= 1'b0;
            writeRegFrom <= '0;
        end else begin
            outValid <= 1'b0;
            if (accept) begin
                aluOperand1  <= operand1;
                aluOperand2  <= operand2;
                imm          <= immIn;
                writeEnable  <= writeEnableIn;
                writeMemFrom <= writeMemFromIn;
                writeRegFrom <= writeRegFromIn;
                if (aluOp == OP_MUL) begin
                    state     <= MUL;
                    busy      <= 1'b1;
                    lane      <= '0;
                    aluResult <= '0;
                end else begin
                    state     <= DONE;
                    aluResult <= comb_res;
                    outValid  <= 1'b1;
                end
            end else if (state == MUL) begin
                aluResult[lane] <= aluOperand1[lane] * aluOperand2[lane];
                if (lane == LW'(vecSize - 1)) begin
                    state    <= DONE;
                    busy     <= 1'b0;
                    outValid <= 1'b1;
                    lane     <= '0;
                end else begin
                    lane <= lane + LW'(1);
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
endmodule
